// File: rtl/posit_result_packer.sv
// posit_result_packer: packs normalized posit words into lane-masked stream
// beats, buffers committed beats in a 2-entry FIFO with a registered head,
// and keeps a saturating count of accepted NaR words.
module posit_result_packer #(
   parameter int unsigned POSIT_WIDTH = 32,
   parameter int unsigned BUS_WIDTH   = 128
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  posit_valid_i,
   output logic                                  posit_ready_o,
   input  logic [POSIT_WIDTH-1:0]                posit_word_i,
   input  logic                                  posit_last_i,
   output logic [BUS_WIDTH-1:0]                  m_tdata_o,
   output logic [BUS_WIDTH/POSIT_WIDTH-1:0]      m_tlane_o,
   output logic                                  m_tlast_o,
   output logic                                  m_tvalid_o,
   input  logic                                  m_tready_i,
   output logic [31:0]                           nar_count_o
);

   localparam int unsigned LANES    = BUS_WIDTH / POSIT_WIDTH;
   localparam int unsigned IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned NAR_W    = 32;
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(LANES - 1);
   localparam logic [POSIT_WIDTH-1:0] NAR_WORD = {1'b1, {(POSIT_WIDTH-1){1'b0}}};
   localparam logic [NAR_W-1:0]       NAR_MAX  = '1;

   // Reject bus/posit width combinations that do not tile into whole lanes.
   if (((BUS_WIDTH % POSIT_WIDTH) != 0) || (LANES < 1)) begin : g_bad_width
      $error("posit_result_packer: BUS_WIDTH must be a nonzero multiple of POSIT_WIDTH");
   end

   // accumulator state
   logic [IDX_W-1:0]       lane_idx_q, lane_idx_d;
   logic [BUS_WIDTH-1:0]   acc_data_q, acc_data_d;
   logic [LANES-1:0]       acc_lane_q, acc_lane_d;

   // FIFO state: head entry drives the stream outputs directly
   logic [CNT_W-1:0]       count_q, count_d;
   logic [BUS_WIDTH-1:0]   head_data_q, head_data_d;
   logic [LANES-1:0]       head_lane_q, head_lane_d;
   logic                   head_last_q, head_last_d;
   logic [BUS_WIDTH-1:0]   tail_data_q, tail_data_d;
   logic [LANES-1:0]       tail_lane_q, tail_lane_d;
   logic                   tail_last_q, tail_last_d;
   logic                   valid_q, valid_d;
   logic                   ready_q, ready_d;

   logic [NAR_W-1:0]       nar_q, nar_d;

   // merged beat and handshake terms
   logic [BUS_WIDTH-1:0]   push_data;
   logic [LANES-1:0]       push_lane;
   logic                   accept;
   logic                   commit;
   logic                   pop;

   assign accept = posit_valid_i & ready_q;
   assign pop    = valid_q & m_tready_i;
   assign commit = accept & ((lane_idx_q == LAST_IDX) | posit_last_i);

   // Merge the incoming word into the current lane of the accumulator.
   always_comb begin
      push_data = acc_data_q;
      push_lane = acc_lane_q;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (lane_idx_q == IDX_W'(i)) begin
            push_data[i*POSIT_WIDTH +: POSIT_WIDTH] = posit_word_i;
            push_lane[i]                            = 1'b1;
         end
      end
   end

   // Accumulator next state: grow the partial beat or clear it on commit.
   always_comb begin
      lane_idx_d = lane_idx_q;
      acc_data_d = acc_data_q;
      acc_lane_d = acc_lane_q;
      if (commit) begin
         lane_idx_d = '0;
         acc_data_d = '0;
         acc_lane_d = '0;
      end else if (accept) begin
         lane_idx_d = lane_idx_q + IDX_W'(1);
         acc_data_d = push_data;
         acc_lane_d = push_lane;
      end
   end

   // FIFO next state; a push never arrives while full since ready is low.
   always_comb begin
      count_d     = count_q;
      head_data_d = head_data_q;
      head_lane_d = head_lane_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_lane_d = tail_lane_q;
      tail_last_d = tail_last_q;
      unique case (count_q)
         CNT_W'(0): begin
            if (commit) begin
               head_data_d = push_data;
               head_lane_d = push_lane;
               head_last_d = posit_last_i;
               count_d     = CNT_W'(1);
            end
         end
         CNT_W'(1): begin
            if (commit && pop) begin
               head_data_d = push_data;
               head_lane_d = push_lane;
               head_last_d = posit_last_i;
            end else if (commit) begin
               tail_data_d = push_data;
               tail_lane_d = push_lane;
               tail_last_d = posit_last_i;
               count_d     = CNT_W'(2);
            end else if (pop) begin
               count_d     = CNT_W'(0);
            end
         end
         CNT_W'(2): begin
            if (pop) begin
               head_data_d = tail_data_q;
               head_lane_d = tail_lane_q;
               head_last_d = tail_last_q;
               count_d     = CNT_W'(1);
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
      valid_d = (count_d != CNT_W'(0));
      ready_d = (count_d != CNT_W'(2));
   end

   // Saturating NaR counter on accepted words.
   always_comb begin
      nar_d = nar_q;
      if (accept && (posit_word_i == NAR_WORD) && (nar_q != NAR_MAX)) begin
         nar_d = nar_q + NAR_W'(1);
      end
   end

   // State registers; reset drops the partial beat and all queued beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_idx_q  <= '0;
         acc_data_q  <= '0;
         acc_lane_q  <= '0;
         count_q     <= '0;
         head_data_q <= '0;
         head_lane_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_lane_q <= '0;
         tail_last_q <= 1'b0;
         valid_q     <= 1'b0;
         ready_q     <= 1'b1;
         nar_q       <= '0;
      end else begin
         lane_idx_q  <= lane_idx_d;
         acc_data_q  <= acc_data_d;
         acc_lane_q  <= acc_lane_d;
         count_q     <= count_d;
         head_data_q <= head_data_d;
         head_lane_q <= head_lane_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_lane_q <= tail_lane_d;
         tail_last_q <= tail_last_d;
         valid_q     <= valid_d;
         ready_q     <= ready_d;
         nar_q       <= nar_d;
      end
   end

   assign posit_ready_o = ready_q;
   assign m_tvalid_o    = valid_q;
   assign m_tdata_o     = head_data_q;
   assign m_tlane_o     = head_lane_q;
   assign m_tlast_o     = head_last_q;
   assign nar_count_o   = nar_q;

endmodule
